// File: rtl/gate_drive_pkg.sv
// gate_drive_pkg: shared types and parameter helpers for the gate_drive output stage.
//   gd_state_t       - burst controller states
//   calc_dt_cnt      - dead-time length in clock cycles
//   calc_max_on_cnt  - maximum RUN length in clock cycles
//   calc_stop_cnt    - maximum STOP wait for a terminating edge, in clock cycles
package gate_drive_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StStop,
    StLock,
    StFault
  } gd_state_t;

  // Result must be at least 1 so every phase change gets a both-low gap.
  function automatic int unsigned calc_dt_cnt(input int unsigned clk_mhz,
                                              input int unsigned dead_time_ns);
    return (clk_mhz * dead_time_ns) / 1000;
  endfunction

  function automatic int unsigned calc_max_on_cnt(input int unsigned clk_mhz,
                                                  input int unsigned max_on_us);
    return clk_mhz * max_on_us;
  endfunction

  function automatic int unsigned calc_stop_cnt(input int unsigned clk_mhz,
                                                input int unsigned stop_timeout_us);
    return clk_mhz * stop_timeout_us;
  endfunction

endpackage

// File: rtl/gate_drive_if.sv
// gate_drive_if: signal bundle between the drive source / monitor and gate_drive.
//   sgn     drive phase from the selector (synchronous to clk)
//   intr    interrupter enable (asynchronous)
//   ocd     over-current detect, active-high (asynchronous)
//   out_hi  high-side gate
//   out_lo  low-side gate
//   active  burst in progress
//   fault   over-current shutdown latched
// master: the side that drives sgn/intr/ocd. slave: gate_drive itself.
interface gate_drive_if;

  logic sgn;
  logic intr;
  logic ocd;
  logic out_hi;
  logic out_lo;
  logic active;
  logic fault;

  modport master (
    output sgn,
    output intr,
    output ocd,
    input  out_hi,
    input  out_lo,
    input  active,
    input  fault
  );

  modport slave (
    input  sgn,
    input  intr,
    input  ocd,
    output out_hi,
    output out_lo,
    output active,
    output fault
  );

endinterface

// File: rtl/gate_drive_sync2.sv
// gate_drive_sync2: two-flop synchronizer for an asynchronous level input.
//   clk    destination clock
//   rst_n  asynchronous active-low reset (output resets to 0)
//   d      asynchronous input
//   q      synchronized output, two clk cycles of latency
module gate_drive_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gate_drive.sv
// gate_drive: turns the single-ended drive phase into complementary, dead-time separated
// bridge gate signals, gated into bursts by the interrupter, with a maximum on-time and a
// latched over-current shutdown.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    gate_drive_if.slave: sgn, intr, ocd in; out_hi, out_lo, active, fault out
// All outputs are registered.
module gate_drive
  import gate_drive_pkg::*;
#(
  parameter int unsigned CLK_MHZ         = 100,
  parameter int unsigned DEAD_TIME_NS    = 100,
  parameter int unsigned MAX_ON_US       = 200,
  parameter int unsigned STOP_TIMEOUT_US = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  gate_drive_if.slave  bus
);

  localparam int unsigned DtCnt    = calc_dt_cnt(CLK_MHZ, DEAD_TIME_NS);
  localparam int unsigned MaxOnCnt = calc_max_on_cnt(CLK_MHZ, MAX_ON_US);
  localparam int unsigned StopCnt  = calc_stop_cnt(CLK_MHZ, STOP_TIMEOUT_US);

  localparam int unsigned DtW = $clog2(DtCnt + 1);
  localparam int unsigned OnW = $clog2(MaxOnCnt + 1);
  localparam int unsigned StW = $clog2(StopCnt + 1);

  // The dead counter is loaded with DtCnt-1 on the edge cycle so that the gates are low for
  // exactly DtCnt registered cycles and the new phase appears DtCnt+1 cycles after the edge.
  localparam logic [DtW-1:0] DtLoad = DtW'(DtCnt - 1);
  localparam logic [OnW-1:0] OnLast = OnW'(MaxOnCnt - 1);
  localparam logic [OnW-1:0] OnMax  = OnW'(MaxOnCnt);
  localparam logic [StW-1:0] StLast = StW'(StopCnt - 1);
  localparam logic [StW-1:0] StMax  = StW'(StopCnt);

  logic intr_s;
  logic ocd_s;

  gate_drive_sync2 u_sync_intr (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.intr),
    .q     (intr_s)
  );

  gate_drive_sync2 u_sync_ocd (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.ocd),
    .q     (ocd_s)
  );

  gd_state_t      state_q, state_d;
  logic           sgn_q;
  logic           sgn_edge;
  logic [DtW-1:0] dt_q, dt_d;
  logic [OnW-1:0] on_cnt_q, on_cnt_d;
  logic [StW-1:0] stop_cnt_q, stop_cnt_d;
  logic           out_hi_q, out_hi_d;
  logic           out_lo_q, out_lo_d;
  logic           active_q, active_d;
  logic           fault_q, fault_d;
  logic           gating;
  logic           drive;

  assign sgn_edge = bus.sgn ^ sgn_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (intr_s) state_d = StArm;
      StArm: begin
        if (!intr_s) begin
          state_d = StIdle;
        end else if (sgn_edge) begin
          state_d = StRun;
        end
      end
      // An edge in the RUN->STOP cycle is deliberately not looked at: STOP ends on the next one.
      StRun:   if (!intr_s || (on_cnt_q == OnLast)) state_d = StStop;
      StStop:  if (sgn_edge || (stop_cnt_q == StLast)) state_d = StLock;
      StLock:  if (!intr_s) state_d = StIdle;
      StFault: if (!intr_s && !ocd_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Over-current overrides every other transition; IDLE is already safe.
    if (ocd_s && (state_q != StIdle)) begin
      state_d = StFault;
    end
  end

  always_comb begin
    on_cnt_d = on_cnt_q;
    if ((state_q == StArm) && (state_d == StRun)) begin
      on_cnt_d = '0;
    end else if ((state_q == StRun) && (on_cnt_q != OnMax)) begin
      on_cnt_d = on_cnt_q + OnW'(1);
    end

    stop_cnt_d = stop_cnt_q;
    if ((state_q == StRun) && (state_d == StStop)) begin
      stop_cnt_d = '0;
    end else if ((state_q == StStop) && (stop_cnt_q != StMax)) begin
      stop_cnt_d = stop_cnt_q + StW'(1);
    end

    // Any edge, including one inside dead time, restarts the gap.
    dt_d = dt_q;
    if (sgn_edge) begin
      dt_d = DtLoad;
    end else if (dt_q != '0) begin
      dt_d = dt_q - DtW'(1);
    end
  end

  // Outputs are decoded from the next state so a FAULT entry drops the gates in the same cycle.
  always_comb begin
    gating   = (state_d == StRun) || (state_d == StStop);
    drive    = gating && !sgn_edge && (dt_q == '0);
    out_hi_d = drive && bus.sgn;
    out_lo_d = drive && !bus.sgn;
    active_d = gating;
    fault_d  = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sgn_q      <= 1'b0;
      dt_q       <= '0;
      on_cnt_q   <= '0;
      stop_cnt_q <= '0;
      out_hi_q   <= 1'b0;
      out_lo_q   <= 1'b0;
      active_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sgn_q      <= bus.sgn;
      dt_q       <= dt_d;
      on_cnt_q   <= on_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      out_hi_q   <= out_hi_d;
      out_lo_q   <= out_lo_d;
      active_q   <= active_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.out_hi = out_hi_q;
  assign bus.out_lo = out_lo_q;
  assign bus.active = active_q;
  assign bus.fault  = fault_q;

endmodule

// File: tb/tb_gate_drive.sv
// tb_gate_drive: directed self-checking bench for gate_drive.
// Settings: CLK_MHZ=100, DEAD_TIME_NS=100 (10-cycle dead time), MAX_ON_US=2 (200-cycle
// on-time), STOP_TIMEOUT_US=4 (400-cycle stop wait); sgn half-period 50 cycles.
module tb_gate_drive;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic mon_en;

  gate_drive_if bus ();

  gate_drive #(
    .CLK_MHZ         (100),
    .DEAD_TIME_NS    (100),
    .MAX_ON_US       (2),
    .STOP_TIMEOUT_US (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Change the phase, expect exactly 10 both-low cycles, then the new phase, then idle out
  // the rest of the half-period.
  task automatic drive_half(input logic val, input int half);
    int low_cnt;
    low_cnt = 0;
    bus.sgn = val;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.out_hi && !bus.out_lo) low_cnt++;
    end
    check_eq("dead_low_cycles", low_cnt, 10);
    tick();
    check_eq("phase_hi", bus.out_hi, val);
    check_eq("phase_lo", bus.out_lo, !val);
    check_eq("phase_active", bus.active, 1);
    for (int i = 11; i < half; i++) tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) check_eq("no_overlap", bus.out_hi & bus.out_lo, 0);
  end

  initial begin
    int low_cnt;
    total    = 0;
    bad      = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    bus.sgn  = 1'b0;
    bus.intr = 1'b0;
    bus.ocd  = 1'b0;

    // Reset state
    #23;
    check_eq("rst_out_hi", bus.out_hi, 0);
    check_eq("rst_out_lo", bus.out_lo, 0);
    check_eq("rst_active", bus.active, 0);
    check_eq("rst_fault", bus.fault, 0);
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_n(3);

    // Normal burst into max on-time: four half-periods in RUN, the fifth edge lands in the
    // RUN->STOP cycle and does not end STOP, the sixth edge does.
    bus.intr = 1'b1;
    wait_n(5);
    check_eq("arm_active", bus.active, 0);
    check_eq("arm_out_hi", bus.out_hi, 0);
    drive_half(1'b1, 50);
    drive_half(1'b0, 50);
    drive_half(1'b1, 50);
    drive_half(1'b0, 50);
    drive_half(1'b1, 50);
    bus.sgn = 1'b0;
    tick();
    check_eq("maxon_end_hi", bus.out_hi, 0);
    check_eq("maxon_end_lo", bus.out_lo, 0);
    check_eq("maxon_end_active", bus.active, 0);
    check_eq("maxon_end_fault", bus.fault, 0);
    wait_n(5);
    bus.sgn = 1'b1;
    wait_n(15);
    check_eq("lock_hi", bus.out_hi, 0);
    check_eq("lock_lo", bus.out_lo, 0);
    check_eq("lock_active", bus.active, 0);
    bus.intr = 1'b0;
    wait_n(5);

    // intr falls mid half-cycle: the half-cycle completes, next edge ends the burst
    bus.intr = 1'b1;
    wait_n(5);
    drive_half(1'b0, 50);
    bus.sgn = 1'b1;
    wait_n(20);
    bus.intr = 1'b0;
    wait_n(29);
    check_eq("intrfall_hold_hi", bus.out_hi, 1);
    check_eq("intrfall_hold_lo", bus.out_lo, 0);
    check_eq("intrfall_hold_active", bus.active, 1);
    bus.sgn = 1'b0;
    tick();
    check_eq("intrfall_end_hi", bus.out_hi, 0);
    check_eq("intrfall_end_lo", bus.out_lo, 0);
    check_eq("intrfall_end_active", bus.active, 0);
    wait_n(5);

    // sgn stuck after intr falls: STOP gives up after 400 cycles
    bus.intr = 1'b1;
    wait_n(5);
    drive_half(1'b1, 50);
    bus.intr = 1'b0;
    wait_n(402);
    check_eq("stuck_before_active", bus.active, 1);
    check_eq("stuck_before_hi", bus.out_hi, 1);
    tick();
    check_eq("stuck_after_active", bus.active, 0);
    check_eq("stuck_after_hi", bus.out_hi, 0);
    check_eq("stuck_after_lo", bus.out_lo, 0);
    wait_n(5);

    // 3-cycle ocd pulse mid-burst
    bus.intr = 1'b1;
    wait_n(5);
    drive_half(1'b0, 50);
    drive_half(1'b1, 20);
    bus.ocd = 1'b1;
    wait_n(2);
    check_eq("ocd_lat_hi", bus.out_hi, 1);
    check_eq("ocd_lat_fault", bus.fault, 0);
    tick();
    bus.ocd = 1'b0;
    check_eq("ocd_hi", bus.out_hi, 0);
    check_eq("ocd_lo", bus.out_lo, 0);
    check_eq("ocd_fault", bus.fault, 1);
    check_eq("ocd_active", bus.active, 0);
    wait_n(10);
    bus.sgn = 1'b0;
    wait_n(15);
    check_eq("fault_hold", bus.fault, 1);
    check_eq("fault_hold_lo", bus.out_lo, 0);
    bus.intr = 1'b0;
    wait_n(2);
    check_eq("fault_clear_lat", bus.fault, 1);
    tick();
    check_eq("fault_clear", bus.fault, 0);
    wait_n(5);

    // 3-cycle sgn glitch during dead time: gap restarts from the last edge
    bus.intr = 1'b1;
    wait_n(5);
    drive_half(1'b1, 50);
    bus.sgn = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!bus.out_hi && !bus.out_lo) low_cnt++;
    end
    check_eq("glitch_low", low_cnt, 3);
    drive_half(1'b1, 30);

    // Reset mid-burst drops everything without waiting for a clock
    check_eq("pre_rst_hi", bus.out_hi, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_hi", bus.out_hi, 0);
    check_eq("async_rst_lo", bus.out_lo, 0);
    check_eq("async_rst_active", bus.active, 0);
    check_eq("async_rst_fault", bus.fault, 0);
    tick();
    rst_n = 1'b1;
    wait_n(5);
    check_eq("post_rst_active", bus.active, 0);
    check_eq("post_rst_hi", bus.out_hi, 0);
    bus.intr = 1'b0;
    wait_n(5);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
